// File: rtl/wide_alu_pkg.sv
// wide_alu_pkg: shared op, state and 8-bit ALU command encodings for wide_alu_seq
package wide_alu_pkg;
  typedef enum logic [2:0] {OP_ADD = 3'd0, OP_SHL = 3'd1, OP_XOR = 3'd2, OP_AND = 3'd3, OP_OR = 3'd4} wide_op_t;
  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_FIX, S_DONE} seq_state_t;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SHL = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b111;
  // undefined ops fall through to AND, which the sequencer pairs with a zero B operand
  function automatic logic [2:0] alu_cmd_of(input logic [2:0] op);
    return op == OP_ADD ? ALU_ADD :
           op == OP_SHL ? ALU_SHL :
           op == OP_XOR ? ALU_XOR :
           op == OP_OR  ? ALU_OR  : ALU_AND;
  endfunction
endpackage

// File: rtl/wide_alu_seq.sv
// wide_alu_seq: runs 16-bit ADD/SHL/XOR/AND/OR as byte passes through an external 8-bit ALU
//   request side : in_valid/in_ready, in_op, in_a, in_b, sc_in
//   ALU side     : alu_cmd/alu_a/alu_b/alu_sc_i out, alu_rslt/alu_sc_o in
//   result side  : out_valid/out_ready, out_rslt, out_c/out_z/out_n
module wide_alu_seq
  import wide_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        sc_in,
  output logic [2:0]  alu_cmd,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_sc_i,
  input  logic [7:0]  alu_rslt,
  input  logic        alu_sc_o,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_rslt,
  output logic        out_c,
  output logic        out_z,
  output logic        out_n
);
  seq_state_t state, state_n;
  logic [2:0] op;
  logic [15:0] a, b;
  logic sc, c_lo, c;
  logic [7:0] r_lo, r_hi;
  logic bad_op;
  assign bad_op = op > 3'd4;
  always_comb begin
    state_n = state;
    alu_cmd = ALU_ADD;
    alu_a = 8'h00;
    alu_b = 8'h00;
    alu_sc_i = 1'b0;
    case (state)
      S_IDLE: state_n = in_valid ? S_LO : S_IDLE;
      S_LO: begin
        alu_cmd = alu_cmd_of(op);
        alu_a = a[7:0];
        alu_b = bad_op ? 8'h00 : b[7:0];
        alu_sc_i = sc;
        state_n = S_HI;
      end
      S_HI: begin
        alu_cmd = alu_cmd_of(op);
        alu_a = a[15:8];
        alu_b = bad_op ? 8'h00 : b[15:8];
        alu_sc_i = c_lo;
        state_n = op == OP_ADD ? S_FIX : S_DONE;
      end
      // the ALU add has no carry-in, so the low-byte carry is added in a third pass
      S_FIX: begin
        alu_a = r_hi;
        alu_b = {7'b0, c_lo};
        state_n = S_DONE;
      end
      S_DONE: state_n = out_ready ? S_IDLE : S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      op <= '0;
      a <= '0;
      b <= '0;
      sc <= 1'b0;
      c_lo <= 1'b0;
      c <= 1'b0;
      r_lo <= '0;
      r_hi <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && in_valid) begin
        op <= in_op;
        a <= in_a;
        b <= in_b;
        sc <= in_sc_sel(sc_in);
      end
      if (state == S_LO) begin
        r_lo <= alu_rslt;
        c_lo <= alu_sc_o;
      end
      if (state == S_HI) begin
        r_hi <= alu_rslt;
        c <= (op == OP_ADD || op == OP_SHL) & alu_sc_o;
      end
      if (state == S_FIX) begin
        r_hi <= alu_rslt;
        c <= c | alu_sc_o;
      end
    end
  end
  function automatic logic in_sc_sel(input logic s);
    return s;
  endfunction
  assign in_ready = state == S_IDLE;
  assign out_valid = state == S_DONE;
  assign out_rslt = {r_hi, r_lo};
  assign out_c = c;
  // zero flag is qualified so the reset/idle view of an all-zero result reads as 0
  assign out_z = out_valid & ~|out_rslt;
  assign out_n = r_hi[7];
endmodule
